// File: rtl/seven_seg_scanner_pkg.sv
// seg_pkg: shared constants, types and helpers for the 7-segment scanner.
//   SEG_OFF / AN_OFF : blanked (all-off) active-low levels for segments/anodes
//   scan_state_e     : per-slot scan phase (blanking gap, then driving)
//   digit_idx_t      : index of the digit currently being scanned
//   disp_buf_t       : one full display image (4 patterns + 4 decimal points)
//   seg_drive()      : active-high pattern -> active-low cathode levels
package seg_pkg;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_e;

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][6:0] dig;
    logic [NUM_DIGITS-1:0]      dp;
  } disp_buf_t;

  function automatic logic [6:0] seg_drive(input logic [6:0] pattern);
    return ~pattern;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: load-side and pin-side signals of the scanner.
//   master : producer of display patterns (drives load/digits/dp_en), observes pins
//   slave  : the scanner itself
//   load, digit0..3, dp_en  : pattern capture strobe and data
//   seg, dp, an, frame_done : registered active-low display pins and frame pulse
//   brightness              : only present when SEG_DIM_EN is defined
interface seven_seg_scanner_if;
  logic       load;
  logic [6:0] digit0;
  logic [6:0] digit1;
  logic [6:0] digit2;
  logic [6:0] digit3;
  logic [3:0] dp_en;
`ifdef SEG_DIM_EN
  logic [2:0] brightness;
`endif
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  modport master (
    output load, digit0, digit1, digit2, digit3, dp_en,
`ifdef SEG_DIM_EN
    output brightness,
`endif
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, digit0, digit1, digit2, digit3, dp_en,
`ifdef SEG_DIM_EN
    input  brightness,
`endif
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner_timer.sv
// seg_refresh_timer: per-digit slot counter.
//   clk, reset_n : clock, async active-low reset
//   blank_end    : high on the last cycle of the blanking gap of a slot
//   slot_end     : high on the last cycle of a slot; counter returns to 0 next
// The counter only ever wraps through slot_end, never by overflow.
module seg_refresh_timer #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic blank_end,
  output logic slot_end
);
  localparam int CNT_W = $clog2(DIGIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign blank_end = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end  = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes four 7-segment patterns onto one shared
// active-low segment bus with four active-low anodes, inserting a blanking gap
// at the start of every digit slot. New patterns go into a pending buffer and
// are promoted to the displayed buffer only at the frame boundary (last cycle
// of digit 3), so a frame is never torn.
//   clk, reset_n : clock, async active-low reset (pins blank immediately)
//   bus (slave)  : load/digit0..3/dp_en in; seg/dp/an/frame_done out (registered)
// Optional feature macro SEG_DIM_EN: adds bus.brightness[2:0] and a free-running
// 3-bit PWM counter gating the anode during the drive phase.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  seven_seg_scanner_if.slave  bus
);
  logic        blank_end, slot_end, boundary, drive_on, an_on;
  scan_state_e state_q, state_d;
  digit_idx_t  idx_q, idx_d;
  disp_buf_t   pend_q, pend_d, act_q, act_d, live;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;
  logic        fd_q, fd_d;
`ifdef SEG_DIM_EN
  logic [2:0]  pwm_q, pwm_d;
`endif

  seg_refresh_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  assign live     = {bus.digit3, bus.digit2, bus.digit1, bus.digit0, bus.dp_en};
  assign boundary = (state_q == ST_DRIVE) && slot_end && (idx_q == 2'd3);
  assign drive_on = (state_q == ST_DRIVE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_BLANK: if (blank_end) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_end) begin
        state_d = ST_BLANK;
        idx_d   = digit_idx_t'(idx_q + 1'b1);
      end
      default:  state_d = ST_BLANK;
    endcase

    pend_d = bus.load ? live : pend_q;
    // pend_d already carries a same-cycle load, giving the boundary bypass.
    act_d  = boundary ? pend_d : act_q;
    fd_d   = boundary;

`ifdef SEG_DIM_EN
    pwm_d  = pwm_q + 3'd1;
    an_on  = drive_on && (pwm_q <= bus.brightness);
`else
    an_on  = drive_on;
`endif

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (drive_on) begin
      seg_d = seg_drive(act_q.dig[idx_q]);
      dp_d  = ~act_q.dp[idx_q];
      if (an_on) an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      an_q    <= AN_OFF;
      fd_q    <= 1'b0;
`ifdef SEG_DIM_EN
      pwm_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
`ifdef SEG_DIM_EN
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (DIGIT_CYCLES=8, BLANK_CYCLES=2).
// A reference model derives the expected pins from the cycle count since reset
// and the history of loads; expected values are queued on each clock and a
// separate monitor pops and compares them on the falling edge.
module tb_seven_seg_scanner;
  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * DC;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } pins_t;

  typedef struct {
    int               q;
    logic [3:0][6:0]  d;
    logic [3:0]       dp;
  } load_rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  seven_seg_scanner_if ifc();

  seven_seg_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  load_rec_t hist[$];
  pins_t     sb[$];
  int        cyc = 0;
  bit        running = 1'b0;
  int        checks = 0;
  int        passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s @%0t got=%h exp=%h", name, $time, got, exp);
  endtask

  // Expected pins after s clock edges since reset release. The pins show the
  // scan position of the previous cycle; frame f shows the newest load that
  // was sampled before frame f began.
  function automatic pins_t model(input int s);
    pins_t           r;
    int              p, pos, idx, f;
    logic [3:0][6:0] d;
    logic [3:0]      dpe;
    bit              on;
    p   = s - 1;
    pos = p % DC;
    idx = (p / DC) % 4;
    f   = p / FRAME;
    d   = '0;
    dpe = '0;
    foreach (hist[i]) if (hist[i].q < FRAME * f) begin
      d   = hist[i].d;
      dpe = hist[i].dp;
    end
    r.an  = 4'hF;
    r.seg = 7'h7F;
    r.dp  = 1'b1;
    r.fd  = (s % FRAME == 0);
    if (pos >= BC) begin
      r.seg = ~d[idx];
      r.dp  = ~dpe[idx];
      on    = 1'b1;
`ifdef SEG_DIM_EN
      on    = ((p % 8) <= int'(ifc.brightness));
`endif
      if (on) r.an[idx] = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (running) begin
      cyc++;
      sb.push_back(model(cyc));
    end
  end

  always @(negedge clk) begin
    pins_t e, g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = '{an: ifc.an, seg: ifc.seg, dp: ifc.dp, fd: ifc.frame_done};
      check("pins{an,seg,dp,fd}", 32'(g), 32'(e));
      check("an_onehot_low", 32'($countones(~ifc.an) <= 1), 32'd1);
    end
  end

  // Called on a falling edge; the strobe is sampled at the next rising edge.
  task automatic do_load(input logic [6:0] d0, d1, d2, d3, input logic [3:0] dpe);
    load_rec_t r;
    ifc.digit0 = d0; ifc.digit1 = d1; ifc.digit2 = d2; ifc.digit3 = d3;
    ifc.dp_en  = dpe;
    ifc.load   = 1'b1;
    r.q  = cyc;
    r.d  = {d3, d2, d1, d0};
    r.dp = dpe;
    hist.push_back(r);
    @(negedge clk);
    ifc.load = 1'b0;
  endtask

  task automatic check_blank(input string name);
    check(name, 32'({ifc.an, ifc.seg, ifc.dp, ifc.frame_done}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.load = 1'b0;
    ifc.digit0 = '0; ifc.digit1 = '0; ifc.digit2 = '0; ifc.digit3 = '0;
    ifc.dp_en = '0;
`ifdef SEG_DIM_EN
    ifc.brightness = 3'd7;
`endif
    repeat (3) @(negedge clk);
    check_blank("reset_pins");
    cyc = 0; running = 1'b1; reset_n = 1'b1;

    repeat (40) @(negedge clk);
    do_load(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0001);
    repeat (80) @(negedge clk);

    // two loads in one frame: the later wins
    do_load(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000);
    repeat (5) @(negedge clk);
    do_load(7'h06, 7'h00, 7'h00, 7'h00, 4'b0000);
    repeat (70) @(negedge clk);

    // load in the boundary cycle itself goes straight to the next frame
    for (int g = 0; g < 2 * FRAME && (cyc % FRAME) != FRAME - 1; g++) @(negedge clk);
    check("boundary_wait", 32'(cyc % FRAME), 32'(FRAME - 1));
    do_load(7'h7D, 7'h01, 7'h02, 7'h04, 4'b1000);
    repeat (70) @(negedge clk);

    // 10-frame random-load run
    repeat (10 * FRAME) begin
`ifdef SEG_DIM_EN
      if ($urandom_range(0, 15) == 0) ifc.brightness = 3'($urandom_range(0, 7));
`endif
      if ($urandom_range(0, 9) == 0)
        do_load(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 4'($urandom));
      else
        @(negedge clk);
    end

`ifdef SEG_DIM_EN
    ifc.brightness = 3'd3;
    repeat (FRAME) @(negedge clk);
    ifc.brightness = 3'd7;
    repeat (FRAME) @(negedge clk);
`endif

    // async reset during digit 2 drive
    for (int g = 0; g < 2 * FRAME && !((cyc % FRAME) >= 2 * DC + BC && (cyc % FRAME) <= 3 * DC - 2); g++)
      @(negedge clk);
    check("digit2_wait", 32'((cyc % FRAME) >= 2 * DC + BC && (cyc % FRAME) <= 3 * DC - 2), 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    running = 1'b0;
    sb.delete();
    #1;
    check_blank("async_reset_blank");
    hist.delete();
    repeat (3) @(negedge clk);
    check_blank("reset_hold_blank");
    cyc = 0; running = 1'b1; reset_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    do_load(7'h6D, 7'h7D, 7'h07, 7'h7F, 4'b0110);
    repeat (2 * FRAME + 4) @(negedge clk);

    running = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
